// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: ALU opcodes, the
// architectural flag bundle, and helpers that classify opcodes for flag
// update and saturation.
package cpu_pkg;

    localparam int CTRL_W = 5;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 5'h00;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 5'h01;
    localparam logic [CTRL_W-1:0] ALU_AND  = 5'h02;
    localparam logic [CTRL_W-1:0] ALU_OR   = 5'h03;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 5'h04;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 5'h05;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 5'h06;
    localparam logic [CTRL_W-1:0] ALU_IMML = 5'h08;
    localparam logic [CTRL_W-1:0] ALU_IMMH = 5'h09;
    localparam logic [CTRL_W-1:0] ALU_LDA  = 5'h0A;
    localparam logic [CTRL_W-1:0] ALU_STA  = 5'h0B;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    // Add/sub class: the only opcodes whose overflow is meaningful
    function automatic logic is_addsub(input logic [CTRL_W-1:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

    // Logic/shift class: updates Z and N but leaves V alone
    function automatic logic sets_zn(input logic [CTRL_W-1:0] ctrl);
        return (ctrl >= ALU_AND) && (ctrl <= ALU_SRA);
    endfunction

endpackage

// File: rtl/flag_unit.sv
// Architectural Z/V/N flag register. Decides which flags a captured
// instruction may touch, based on its opcode class.
module flag_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [DATA_W-1:0] res,
    input  logic              ovfl,
    output flags_t            flags
);

    flags_t flags_next;

    // Select the new flag values from the opcode class; default is hold
    always_comb begin
        flags_next = flags;
        if (en) begin
            if (is_addsub(ctrl)) begin
                flags_next.z = (res == '0);
                flags_next.n = res[DATA_W-1];
                flags_next.v = ovfl;
            end else if (sets_zn(ctrl)) begin
                flags_next.z = (res == '0);
                flags_next.n = res[DATA_W-1];
            end
        end
    end

    // Flag register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else begin
            flags <= flags_next;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register. Captures the ALU result and instruction
// side-band, optionally clamps add/sub results on overflow, and drives the
// flag unit. Edge priority is reset, then flush, then stall, then load.
module ex_mem_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_alu_out,
    input  logic                  ex_ovfl,
    input  logic [CTRL_W-1:0]     ex_ctrl,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wr_en,
    input  logic                  ex_mem_rd,
    input  logic                  ex_mem_wr,
    input  logic [DATA_W-1:0]     ex_store_data,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_alu_out,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_wr_en,
    output logic                  mem_mem_rd,
    output logic                  mem_mem_wr,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic                  flag_z,
    output logic                  flag_v,
    output logic                  flag_n
);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] res_next;
    logic              flag_en;
    flags_t            flags;

    // Clamp overflowing add/sub results; a wrapped negative result means the
    // true value overflowed positive, and vice versa
    always_comb begin
        res_next = ex_alu_out;
        if (SATURATE && ex_valid && is_addsub(ex_ctrl) && ex_ovfl) begin
            res_next = ex_alu_out[DATA_W-1] ? SAT_MAX : SAT_MIN;
        end
    end

    assign flag_en = !stall && !flush && ex_valid;

    // Pipeline register: flush inserts an all-zero bubble, stall holds
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_valid      <= 1'b0;
            mem_alu_out    <= '0;
            mem_rd         <= '0;
            mem_wr_en      <= 1'b0;
            mem_mem_rd     <= 1'b0;
            mem_mem_wr     <= 1'b0;
            mem_store_data <= '0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_alu_out    <= res_next;
            mem_rd         <= ex_rd;
            mem_wr_en      <= ex_wr_en  && ex_valid;
            mem_mem_rd     <= ex_mem_rd && ex_valid;
            mem_mem_wr     <= ex_mem_wr && ex_valid;
            mem_store_data <= ex_store_data;
        end
    end

    flag_unit #(
        .DATA_W (DATA_W)
    ) u_flag_unit (
        .clk   (clk),
        .rst   (rst),
        .en    (flag_en),
        .ctrl  (ex_ctrl),
        .res   (res_next),
        .ovfl  (ex_ovfl),
        .flags (flags)
    );

    assign flag_z = flags.z;
    assign flag_v = flags.v;
    assign flag_n = flags.n;

endmodule
